// File: rtl/sparse_pkg.sv
// Shared definitions for the pair-packed sparse weight memory.
// Used by the write-side packer and by the read-side unpacker.
//   INDEX_WIDTH_DEF / VALUE_WIDTH_DEF : default entry field widths
//   WORD_WIDTH                        : packed pair-word width
//   state_e                           : packer FSM states
//   pack_pair()                       : builds {idx1, val1, idx0, val0}
package sparse_pkg;

    localparam int unsigned INDEX_WIDTH_DEF = 12;
    localparam int unsigned VALUE_WIDTH_DEF = 8;
    localparam int unsigned WORD_WIDTH      = 2 * (INDEX_WIDTH_DEF + VALUE_WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

    // Entry 0 occupies the low half; the value sits in the LSBs of each half.
    function automatic logic [WORD_WIDTH-1:0] pack_pair(
        input logic [INDEX_WIDTH_DEF-1:0] idx1,
        input logic [VALUE_WIDTH_DEF-1:0] val1,
        input logic [INDEX_WIDTH_DEF-1:0] idx0,
        input logic [VALUE_WIDTH_DEF-1:0] val0
    );
        return {idx1, val1, idx0, val0};
    endfunction

endpackage

// File: rtl/sparse_weight_packer_if.sv
// Bus bundle for sparse_weight_packer: layer control, dense input stream,
// weight-RAM write port and layer status.
//   master : drives start / in_valid / in_value / in_last
//   slave  : the packer; drives in_ready, wr_*, done, counts, overflow
interface sparse_weight_packer_if #(
    parameter int unsigned DEPTH_PAIRS = 512,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned VALUE_WIDTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH_PAIRS);

    logic                                   start;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [VALUE_WIDTH-1:0]                 in_value;
    logic                                   in_last;
    logic                                   wr_en;
    logic [AW-1:0]                          wr_addr;
    logic [2*(INDEX_WIDTH+VALUE_WIDTH)-1:0] wr_data;
    logic                                   done;
    logic [AW+1:0]                          nnz_count;
    logic [AW:0]                            word_count;
    logic                                   overflow;

    modport master (
        output start, in_valid, in_value, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, done, nnz_count, word_count, overflow
    );

    modport slave (
        input  start, in_valid, in_value, in_last,
        output in_ready, wr_en, wr_addr, wr_data, done, nnz_count, word_count, overflow
    );

endinterface

// File: rtl/sparse_weight_packer.sv
// Write-side encoder for the pair-packed sparse weight memory.
// Drops zero weights from a dense layer stream, tags survivors with their
// dense position and packs two (index, value) entries per RAM word.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sparse_weight_packer_if.slave (stream in, RAM write out, status)
module sparse_weight_packer
    import sparse_pkg::*;
#(
    parameter int unsigned DEPTH_PAIRS = 512,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEF,
    parameter int unsigned VALUE_WIDTH = VALUE_WIDTH_DEF
) (
    input logic                   clk,
    input logic                   rst,
    sparse_weight_packer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_PAIRS);
    localparam int unsigned PW = INDEX_WIDTH + 1;
    localparam int unsigned HW = INDEX_WIDTH + VALUE_WIDTH;
    localparam int unsigned WW = 2 * HW;
    localparam int unsigned NW = AW + 2;
    localparam int unsigned CW = AW + 1;

    localparam logic [PW-1:0] POS_ONE = PW'(1);
    localparam logic [CW-1:0] WC_ONE  = CW'(1);
    localparam logic [CW-1:0] WC_FULL = CW'(DEPTH_PAIRS);
    localparam logic [NW-1:0] NNZ_ONE = NW'(1);
    localparam logic [NW-1:0] NNZ_TWO = NW'(2);

    state_e          state_q, state_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            slot_full_q, slot_full_d;
    logic [HW-1:0]   slot_q, slot_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [WW-1:0]   wr_data_q, wr_data_d;
    logic            done_q, done_d;
    logic [NW-1:0]   nnz_q, nnz_d;
    logic [CW-1:0]   wc_q, wc_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic            nonzero;
    logic            entry_ok;
    logic [HW-1:0]   entry;
    logic            want_wr;
    logic [WW-1:0]   want_data;
    logic [NW-1:0]   want_nnz;

    assign accept   = bus.in_valid && (state_q == RUN);
    assign nonzero  = (bus.in_value != '0);
    // Position MSB set means the index no longer fits the entry field.
    assign entry_ok = nonzero && !pos_q[INDEX_WIDTH];
    assign entry    = {pos_q[INDEX_WIDTH-1:0], bus.in_value};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (accept && bus.in_last) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pos_d       = pos_q;
        slot_full_d = slot_full_q;
        slot_d      = slot_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = (state_q == FIN);
        nnz_d       = nnz_q;
        wc_d        = wc_q;
        ovf_d       = ovf_q;
        want_wr     = 1'b0;
        want_data   = '0;
        want_nnz    = '0;

        if ((state_q == IDLE) && bus.start) begin
            pos_d       = '0;
            slot_full_d = 1'b0;
            nnz_d       = '0;
            wc_d        = '0;
            ovf_d       = 1'b0;
        end else if (accept) begin
            pos_d = pos_q + POS_ONE;
            if (nonzero && !entry_ok) begin
                ovf_d = 1'b1;
            end
            // At most one word per beat: a completed pair and a tail pad
            // can never both arise from the same beat.
            if (entry_ok) begin
                if (slot_full_q) begin
                    want_wr     = 1'b1;
                    want_data   = {entry, slot_q};
                    want_nnz    = NNZ_TWO;
                    slot_full_d = 1'b0;
                end else if (bus.in_last) begin
                    want_wr   = 1'b1;
                    want_data = {HW'(0), entry};
                    want_nnz  = NNZ_ONE;
                end else begin
                    slot_full_d = 1'b1;
                    slot_d      = entry;
                end
            end else if (bus.in_last && slot_full_q) begin
                want_wr     = 1'b1;
                want_data   = {HW'(0), slot_q};
                want_nnz    = NNZ_ONE;
                slot_full_d = 1'b0;
            end

            if (want_wr) begin
                if (wc_q == WC_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wc_q[AW-1:0];
                    wr_data_d = want_data;
                    wc_d      = wc_q + WC_ONE;
                    nnz_d     = nnz_q + want_nnz;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q       <= '0;
            slot_full_q <= 1'b0;
            slot_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            nnz_q       <= '0;
            wc_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            slot_full_q <= slot_full_d;
            slot_q      <= slot_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            nnz_q       <= nnz_d;
            wc_q        <= wc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready   = (state_q == RUN);
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.done       = done_q;
    assign bus.nnz_count  = nnz_q;
    assign bus.word_count = wc_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_sparse_weight_packer.sv
// Scoreboard bench for sparse_weight_packer. Two instances share one input
// stream: a full-size one (512 pairs, 12-bit index) and a tiny one
// (2 pairs, 4-bit index) so word and index overflow are reached quickly.
module tb_sparse_weight_packer;

    typedef struct {
        int              trig;
        int              addr;
        longint unsigned data;
        int              wc;
        int              nnz;
        int              cyc;
    } wr_t;

    typedef struct {
        int nnz;
        int wc;
        int ovf;
        int cyc;
    } dn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_value = '0;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    int iw[2]    = '{12, 4};
    int depth[2] = '{512, 2};

    wr_t pend[2][$];
    dn_t pdone[2];
    wr_t sbw[2][$];
    dn_t sbd[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sparse_weight_packer_if #(.DEPTH_PAIRS(512), .INDEX_WIDTH(12), .VALUE_WIDTH(8)) bus_a ();
    sparse_weight_packer_if #(.DEPTH_PAIRS(2),   .INDEX_WIDTH(4),  .VALUE_WIDTH(8)) bus_b ();

    assign bus_a.start    = start;
    assign bus_a.in_valid = in_valid;
    assign bus_a.in_value = in_value;
    assign bus_a.in_last  = in_last;
    assign bus_b.start    = start;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_value = in_value;
    assign bus_b.in_last  = in_last;

    sparse_weight_packer #(.DEPTH_PAIRS(512), .INDEX_WIDTH(12), .VALUE_WIDTH(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sparse_weight_packer #(.DEPTH_PAIRS(2), .INDEX_WIDTH(4), .VALUE_WIDTH(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: list the surviving entries, pair them in order, pad an odd
    // tail, then keep only as many words as the memory holds.
    task automatic model_layer(input int d, input int vals[$]);
        int              ei[$];
        int              ev[$];
        int              nw;
        int              nnz;
        int              ovf;
        int              real_n;
        longint unsigned h0;
        longint unsigned h1;
        wr_t             w;
        pend[d].delete();
        nw = 0;
        nnz = 0;
        ovf = 0;
        foreach (vals[i]) begin
            if ((vals[i] & 255) != 0) begin
                if (i >= (1 << iw[d])) begin
                    ovf = 1;
                end else begin
                    ei.push_back(i);
                    ev.push_back(vals[i] & 255);
                end
            end
        end
        for (int k = 0; k < ei.size(); k += 2) begin
            h0 = (longint'(ei[k]) << 8) | longint'(ev[k]);
            if (k + 1 < ei.size()) begin
                h1     = (longint'(ei[k+1]) << 8) | longint'(ev[k+1]);
                w.trig = ei[k+1];
                real_n = 2;
            end else begin
                h1     = 0;
                w.trig = vals.size() - 1;
                real_n = 1;
            end
            if (nw < depth[d]) begin
                w.addr = nw;
                nw++;
                nnz += real_n;
                w.data = (h1 << (iw[d] + 8)) | h0;
                w.wc   = nw;
                w.nnz  = nnz;
                w.cyc  = 0;
                pend[d].push_back(w);
            end else begin
                ovf = 1;
            end
        end
        pdone[d] = '{nnz, nw, ovf, 0};
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " a in_ready"},   longint'(bus_a.in_ready),   0);
        check({tag, " a wr_en"},      longint'(bus_a.wr_en),      0);
        check({tag, " a wr_addr"},    longint'(bus_a.wr_addr),    0);
        check({tag, " a wr_data"},    longint'(bus_a.wr_data),    0);
        check({tag, " a done"},       longint'(bus_a.done),       0);
        check({tag, " a nnz_count"},  longint'(bus_a.nnz_count),  0);
        check({tag, " a word_count"}, longint'(bus_a.word_count), 0);
        check({tag, " a overflow"},   longint'(bus_a.overflow),   0);
        check({tag, " b wr_en"},      longint'(bus_b.wr_en),      0);
        check({tag, " b word_count"}, longint'(bus_b.word_count), 0);
        check({tag, " b overflow"},   longint'(bus_b.overflow),   0);
    endtask

    task automatic run_layer(input int vals[$], input int abort_at, input int start_mid,
                             input int long_gap_at, input int rnd_gaps);
        int  g;
        wr_t w;
        dn_t dn;
        for (int d = 0; d < 2; d++) model_layer(d, vals);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a in_ready after start", longint'(bus_a.in_ready), 1);
        check("b in_ready after start", longint'(bus_b.in_ready), 1);
        for (int i = 0; i < vals.size(); i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                in_last = 1'b0;
                #1;
                reset_checks("midreset");
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("dut%0d writes pending at reset", d), longint'(sbw[d].size()), 0);
                    sbw[d].delete();
                    sbd[d].delete();
                    pend[d].delete();
                end
                tick();
                rst = 1'b0;
                tick();
                return;
            end
            if (i == long_gap_at) g = 5;
            else if (rnd_gaps != 0 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 2);
            else g = 0;
            repeat (g) begin
                in_valid = 1'b0;
                start    = 1'b0;
                in_value = 8'($urandom);
                in_last  = 1'($urandom_range(0, 1));
                tick();
            end
            in_valid = 1'b1;
            in_value = 8'(vals[i]);
            in_last  = (i == vals.size() - 1);
            start    = (start_mid != 0) && (i == vals.size() / 2);
            for (int d = 0; d < 2; d++) begin
                while (pend[d].size() > 0 && pend[d][0].trig == i) begin
                    w = pend[d].pop_front();
                    w.cyc = cyc + 1;
                    sbw[d].push_back(w);
                end
                if (i == vals.size() - 1) begin
                    dn = pdone[d];
                    dn.cyc = cyc + 2;
                    sbd[d].push_back(dn);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        for (int t = 0; t < 8 && (sbd[0].size() != 0 || sbd[1].size() != 0); t++) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d done timeout", d), longint'(sbd[d].size()), 0);
            check($sformatf("dut%0d writes outstanding", d), longint'(sbw[d].size()), 0);
            sbd[d].delete();
            sbw[d].delete();
        end
        tick();
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a write or done.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                logic            we;
                logic            dn_s;
                logic            rdy;
                longint unsigned addr;
                longint unsigned data;
                longint unsigned wc;
                longint unsigned nnz;
                longint unsigned ovf;
                wr_t             w;
                dn_t             e;
                if (d == 0) begin
                    we = bus_a.wr_en; dn_s = bus_a.done; rdy = bus_a.in_ready;
                    addr = longint'(bus_a.wr_addr); data = longint'(bus_a.wr_data);
                    wc = longint'(bus_a.word_count); nnz = longint'(bus_a.nnz_count);
                    ovf = longint'(bus_a.overflow);
                end else begin
                    we = bus_b.wr_en; dn_s = bus_b.done; rdy = bus_b.in_ready;
                    addr = longint'(bus_b.wr_addr); data = longint'(bus_b.wr_data);
                    wc = longint'(bus_b.word_count); nnz = longint'(bus_b.nnz_count);
                    ovf = longint'(bus_b.overflow);
                end
                if (we) begin
                    if (sbw[d].size() == 0) begin
                        check($sformatf("dut%0d unexpected wr_en", d), 1, 0);
                    end else begin
                        w = sbw[d].pop_front();
                        check($sformatf("dut%0d wr_addr", d), addr, longint'(w.addr));
                        check($sformatf("dut%0d wr_data", d), data, w.data);
                        check($sformatf("dut%0d word_count at write", d), wc, longint'(w.wc));
                        check($sformatf("dut%0d nnz_count at write", d), nnz, longint'(w.nnz));
                        check($sformatf("dut%0d write cycle", d), longint'(cyc), longint'(w.cyc));
                    end
                end
                if (dn_s) begin
                    if (sbd[d].size() == 0) begin
                        check($sformatf("dut%0d unexpected done", d), 1, 0);
                    end else begin
                        e = sbd[d].pop_front();
                        check($sformatf("dut%0d done cycle", d), longint'(cyc), longint'(e.cyc));
                        check($sformatf("dut%0d nnz_count", d), nnz, longint'(e.nnz));
                        check($sformatf("dut%0d word_count", d), wc, longint'(e.wc));
                        check($sformatf("dut%0d overflow", d), ovf, longint'(e.ovf));
                        check($sformatf("dut%0d in_ready at done", d), longint'(rdy), 0);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int q[$];
        int len;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        rst = 1'b0;
        tick();

        q = '{3, 0, 0, 254, 5, 0, 7};
        run_layer(q, -1, 0, -1, 0);

        q = '{0, 9};
        run_layer(q, -1, 0, -1, 0);

        q.delete();
        repeat (16) q.push_back(0);
        run_layer(q, -1, 0, -1, 0);

        q = '{1, 2, 3, 4, 5, 6};
        run_layer(q, -1, 0, -1, 0);

        q = '{11, 12, 13, 14, 15};
        run_layer(q, 3, 0, -1, 0);
        q = '{3, 0, 0, 254, 5, 0, 7};
        run_layer(q, -1, 0, -1, 0);

        q = '{21, 0, 22, 23, 0, 0, 24, 25, 26, 0, 27, 28};
        run_layer(q, -1, 1, 4, 0);

        repeat (25) begin
            len = $urandom_range(1, 30);
            q.delete();
            for (int i = 0; i < len; i++) begin
                q.push_back(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255)));
            end
            run_layer(q, -1, int'($urandom_range(0, 1)), -1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sparse_weight_packer.md
# sparse_weight_packer

Write-side encoder for the pair-packed sparse weight memory. It consumes a dense, pruned weight stream for one layer and drops zero-valued weights. Each surviving weight is tagged with its dense position index, and two (index, value) entries are packed into one word. Each word is emitted on a single-cycle write port that drives the write side of the weight RAM consumed by the sparse MAC array.

## Interface
Parameters:
- DEPTH_PAIRS, 512, number of pair-words in the target memory
- INDEX_WIDTH, 12, dense position index width
- VALUE_WIDTH, 8, weight value width (two's complement)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a layer; honoured only in IDLE
- in_valid  in  1  dense weight beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_value  in  VALUE_WIDTH  dense weight; 0 means pruned
- in_last  in  1  marks final dense beat of the layer
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  $clog2(DEPTH_PAIRS)  pair-word address
- wr_data  out  2*(INDEX_WIDTH+VALUE_WIDTH)  packed word
- done  out  1  one-cycle pulse at end of layer
- nnz_count  out  $clog2(DEPTH_PAIRS)+2  nonzero entries written, excluding padding
- word_count  out  $clog2(DEPTH_PAIRS)+1  words written
- overflow  out  1  sticky error flag; cleared by start

## Operation
- Word format, LSB-first:
  - [IW+VW-1:0] = {idx0, val0}
  - [2(IW+VW)-1:IW+VW] = {idx1, val1}
  - Value sits in the LSBs of each half.
- FSM states are IDLE, RUN and FIN.
  - IDLE -> RUN on start. Start clears the position counter, the slot, nnz_count, word_count and overflow.
  - RUN -> FIN on an accepted beat with in_last=1.
  - FIN -> IDLE after one cycle; done is asserted in the cycle following FIN.
- in_ready = (state == RUN). There is no backpressure inside RUN.
- Position counter (INDEX_WIDTH+1 bits):
  - Increments on every accepted beat, zero or not.
  - The index of a beat is the counter value before the increment.
- Accepted nonzero beat:
  - Slot empty: latch {pos, value} as entry 0 and mark the slot full.
  - Slot full: write {pos, value, idx0, val0} and clear the slot.
- Accepted zero beat: no entry is produced, only the position advances.
- Tail on in_last:
  - If an odd entry remains after processing the last beat, write it padded with idx1=0, val1=0. The pad is harmless because its value is zero.
  - At most one write results from the last beat.
- Every write increments wr_addr and word_count. nnz_count counts only real entries.
- Overflow handling:
  - If a write is required while word_count == DEPTH_PAIRS, suppress wr_en and set overflow.
  - If a nonzero beat arrives with pos >= 2^INDEX_WIDTH, drop it and set overflow.
  - The layer still completes and done still pulses.
- start outside IDLE is ignored.
- in_last on a beat with in_valid low has no effect.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, nnz_count=0, word_count=0, overflow=0, state=IDLE, slot empty.
- Reset mid-layer aborts immediately. Memory contents already written are not touched, and no done is issued.
- wr_en, wr_addr and wr_data are registered. A beat accepted at edge t produces its write in cycle t+1.
- For the last beat accepted at edge t:
  - The write, if any, appears in cycle t+1.
  - in_ready is low from cycle t+1.
  - done is high in cycle t+2 only.
- Sustained throughput is one dense beat per clock, and at most one write per clock.
- nnz_count and word_count update in the same cycle as the corresponding wr_en.

## Structure
- Shared package sparse_pkg holds:
  - WORD_WIDTH = 2*(INDEX_WIDTH+VALUE_WIDTH)
  - a pack_pair(idx1, val1, idx0, val0) function
  - the state encoding (IDLE, RUN, FIN)
  - the read-side module reuses the same package for unpacking.
- The block is flat; no sub-module is warranted.

## Test plan
- Dense stream [3,0,0,-2,5,0,7(last)]:
  - writes 0x00700_00503? No, exact contents: addr0 = {idx1=3, val1=0xFE, idx0=0, val0=0x03}; addr1 = {idx1=6, val1=0x07, idx0=4, val0=0x05}
  - nnz_count=4, word_count=2, done 2 cycles after the last accept.
- Odd count [0,9(last)]:
  - one write at addr0 = {idx1=0, val1=0, idx0=1, val0=0x09}
  - nnz_count=1.
- All-zero stream of 16 beats: no wr_en, done pulses, both counts 0.
- DEPTH_PAIRS=2, 6 nonzero beats: two writes, third suppressed, overflow=1, done still pulses.
- Reset asserted mid-layer after 3 nonzero beats:
  - outputs return to reset values, and a subsequent start re-writes from addr0.
- start pulsed during RUN is ignored, and in_valid held low for 5 cycles mid-stream does not disturb indices.
